// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch front end.
// Imported by the fetch interface, the fetch queue and the fetch unit top.
package fetch_pkg;

    localparam int ILEN = 32;
    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    // Saturating 32-bit accumulate used by the optional performance counters.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/grant/response bus between the fetch unit and imem.
// The fetch unit is the master; the memory (or a bench model) is the slave.
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [ILEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_queue.sv
// FIFO of fetched {instr, pc} entries with a registered head, flush, and
// push/pop in the same cycle (also when full).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output fetch_entry_t     head
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_P  = PTR_W'(DEPTH - 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] remaining;
    logic             do_push, do_pop;
    fetch_entry_t     head_n;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        do_pop    = pop && (count != '0);
        do_push   = push && ((count != DEPTH_C) || do_pop);
        rd_ptr_n  = do_pop  ? ptr_inc(rd_ptr) : rd_ptr;
        wr_ptr_n  = do_push ? ptr_inc(wr_ptr) : wr_ptr;
        remaining = count - CNT_W'(do_pop);
        count_n   = remaining + CNT_W'(do_push);
        head_n    = head;

        // The next head is an older stored entry if one survives the pop,
        // otherwise the word being pushed lands straight in the head register.
        if (remaining != '0) begin
            head_n = mem[rd_ptr_n];
        end else if (do_push) begin
            head_n = push_data;
        end

        if (flush) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            count_n  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head       <= '0;
        end else begin
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            count      <= count_n;
            head_valid <= (count_n != '0);
            head       <= head_n;
        end
    end

    // NOTE: the storage array has no reset; count and head_valid gate every
    // read, so its contents never matter until written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch stage: PC, single-outstanding imem requests, queue to decode.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    output logic                      instr_valid,
    output logic [ILEN-1:0]           instr,
    output logic [XLEN-1:0]           instr_pc,
    input  logic                      dec_ready,
    input  logic                      redirect,
    input  logic [XLEN-1:0]           redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_flushed
`endif
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_state_e     state_q, state_n;
    logic [XLEN-1:0]  pc_q, pc_n;
    logic [XLEN-1:0]  cap_pc_q, cap_pc_n;

    logic             outstanding;
    logic             has_slot;
    logic             req;
    logic             grant;
    logic             resp;
    logic             push;
    logic             pop;
    logic             dropped;
    logic [CNT_W-1:0] count;
    fetch_entry_t     push_data;
    fetch_entry_t     head;
    logic             head_valid;

    always_comb begin
        outstanding = (state_q != REQ);
        // Reserving a slot for the in-flight word means a response always fits.
        has_slot    = (count + CNT_W'(outstanding)) < DEPTH_C;
        req         = rst_n && (state_q == REQ) && !redirect && has_slot;
        grant       = req && imem.gnt;
        resp        = imem.rvalid && outstanding;
        push        = resp && (state_q == WAIT) && !redirect;
        dropped     = resp && ((state_q == DROP) || redirect);
        pop         = head_valid && dec_ready && !redirect;
        push_data   = '{instr: imem.rdata, pc: cap_pc_q};
    end

    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        cap_pc_n = cap_pc_q;

        unique case (state_q)
            REQ: begin
                if (grant) begin
                    state_n  = WAIT;
                    pc_n     = pc_q + PC_STEP;
                    cap_pc_n = pc_q;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    state_n = REQ;
                end else if (redirect) begin
                    state_n = DROP;
                end
            end
            DROP: begin
                if (imem.rvalid) begin
                    state_n = REQ;
                end
            end
            default: state_n = REQ;
        endcase

        if (redirect) begin
            pc_n = align_pc(redirect_pc);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= REQ;
            pc_q     <= RESET_PC;
            cap_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            cap_pc_q <= cap_pc_n;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (redirect),
        .count      (count),
        .head_valid (head_valid),
        .head       (head)
    );

    assign imem.req    = req;
    assign imem.addr   = pc_q;
    assign instr_valid = head_valid;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    // Redirect targets are forced word aligned, so the low bits are ignored.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef FETCH_PERF_EN
    logic [31:0] flush_amount;

    always_comb begin
        flush_amount = (redirect ? 32'(count) : 32'd0) + 32'(dropped);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push) begin
                perf_fetched <= sat_add(perf_fetched, 32'd1);
            end
            perf_flushed <= sat_add(perf_flushed, flush_amount);
        end
    end
`else
    logic unused_dropped;
    assign unused_dropped = dropped;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue-based reference model with a
// per-cycle compare, an imem responder with programmable latency, and literal pins.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        dec_ready   = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_bus),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .dec_ready    (dec_ready),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a << 8) | NOP_INSTR;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] a, input int b);
        longint s;
        s = longint'(a) + longint'(b);
        return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    endfunction

    // Reference model: what the fetch unit holds, independent of its encoding.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc      = RESET_PC;
    logic [31:0] m_cap     = RESET_PC;
    logic        m_busy    = 1'b0;
    logic        m_drop    = 1'b0;
    logic [31:0] m_fetched = 32'h0;
    logic [31:0] m_flushed = 32'h0;

    // Memory responder: a grant at edge N yields rvalid sampled at edge N+lat.
    int          lat      = 1;
    int          rv_timer = 0;
    logic [31:0] rv_data  = 32'h0;

    always @(posedge clk) begin : model
        logic        g;
        logic [31:0] gaddr;
        ent_t        e;
        gaddr = m_pc;
        g = rst_n && !m_busy && !redirect && (m_q.size() < DEPTH) && imem_bus.gnt;
        if (!rst_n) begin
            m_pc      = RESET_PC;
            m_busy    = 1'b0;
            m_drop    = 1'b0;
            m_fetched = 32'h0;
            m_flushed = 32'h0;
            m_q.delete();
        end else if (redirect) begin
            m_flushed = sat_inc(m_flushed, m_q.size());
            m_q.delete();
            if (m_busy && imem_bus.rvalid) begin
                m_flushed = sat_inc(m_flushed, 1);
                m_busy    = 1'b0;
                m_drop    = 1'b0;
            end else if (m_busy) begin
                m_drop = 1'b1;
            end
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (m_q.size() > 0 && dec_ready) begin
                void'(m_q.pop_front());
            end
            if (m_busy && imem_bus.rvalid) begin
                if (m_drop) begin
                    m_flushed = sat_inc(m_flushed, 1);
                end else begin
                    e.instr = imem_bus.rdata;
                    e.pc    = m_cap;
                    m_q.push_back(e);
                    m_fetched = sat_inc(m_fetched, 1);
                end
                m_busy = 1'b0;
                m_drop = 1'b0;
            end
            if (g) begin
                m_cap  = m_pc;
                m_pc   = m_pc + 32'd4;
                m_busy = 1'b1;
            end
        end
        if (rv_timer > 0) rv_timer--;
        if (g) begin
            rv_timer = lat;
            rv_data  = instr_of(gaddr);
        end
        #1;
        imem_bus.rvalid = (rv_timer == 1);
        imem_bus.rdata  = (rv_timer == 1) ? rv_data : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin : compare
        logic exp_req;
        exp_req = rst_n && !m_busy && !redirect && (m_q.size() < DEPTH);
        check("imem_req", 32'(imem_bus.req), 32'(exp_req));
        check("imem_addr", imem_bus.addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("instr", instr, m_q[0].instr);
            check("instr_pc", instr_pc, m_q[0].pc);
        end
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_flushed", perf_flushed, m_flushed);
`endif
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        redirect     = 1'b0;
        imem_bus.gnt = 1'b0;
        cyc(2);
        #1;
        check("rst imem_req", 32'(imem_bus.req), 32'h0);
        check("rst imem_addr", imem_bus.addr, RESET_PC);
        check("rst instr_valid", 32'(instr_valid), 32'h0);
        check("rst instr", instr, 32'h0);
        check("rst instr_pc", instr_pc, 32'h0);
`ifdef FETCH_PERF_EN
        check("rst perf_fetched", perf_fetched, 32'h0);
        check("rst perf_flushed", perf_flushed, 32'h0);
`endif
        rst_n = 1'b1;
    endtask

    logic [47:0] rdy_pat;
    logic [47:0] gnt_pat;
    logic [7:0]  lat_pat;

    initial begin
        imem_bus.gnt = 1'b0;

        // Streaming fetch with single-cycle memory latency.
        do_reset();
        imem_bus.gnt = 1'b1; dec_ready = 1'b1; lat = 1;
        #1;
        check("t1 first req", 32'(imem_bus.req), 32'h1);
        check("t1 first addr", imem_bus.addr, 32'h0);
        cyc(1); #1;
        check("t1 req in wait", 32'(imem_bus.req), 32'h0);
        check("t1 addr after grant", imem_bus.addr, 32'h4);
        cyc(1); #1;
        check("t1 valid", 32'(instr_valid), 32'h1);
        check("t1 pc0", instr_pc, 32'h0);
        check("t1 instr0", instr, 32'h0000_0013);
        cyc(1); #1;
        check("t1 addr8", imem_bus.addr, 32'h8);
        cyc(1); #1;
        check("t1 pc4", instr_pc, 32'h4);
        check("t1 instr4", instr, 32'h0000_0413);
        cyc(2); #1;
        check("t1 pc8", instr_pc, 32'h8);

        // Decode stall fills the queue and throttles requests.
        do_reset();
        imem_bus.gnt = 1'b1; dec_ready = 1'b0; lat = 1;
        cyc(10); #1;
        check("t2 req throttled", 32'(imem_bus.req), 32'h0);
        check("t2 head held", instr_pc, 32'h0);
        check("t2 addr", imem_bus.addr, 32'h8);
        dec_ready = 1'b1;
        cyc(1); #1;
        check("t2 second word", instr_pc, 32'h4);
        cyc(2); #1;
        check("t2 third word", instr_pc, 32'h8);

        // Redirect with a request in flight: stale word is dropped.
        do_reset();
        imem_bus.gnt = 1'b1; dec_ready = 1'b1; lat = 3;
        cyc(1);
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        #1;
        check("t3 req masked", 32'(imem_bus.req), 32'h0);
        cyc(1);
        redirect = 1'b0;
        #1;
        check("t3 empty", 32'(instr_valid), 32'h0);
        check("t3 aligned addr", imem_bus.addr, 32'h0000_0100);
        cyc(2); #1;
        check("t3 req after drop", 32'(imem_bus.req), 32'h1);
        cyc(4); #1;
        check("t3 new pc", instr_pc, 32'h0000_0100);
        check("t3 new instr", instr, 32'h0001_0013);
        dec_ready = 1'b0; lat = 1;
        cyc(2);
        redirect = 1'b1; redirect_pc = 32'h0000_0020;
        cyc(1);
        redirect = 1'b0;
        #1;
        check("t3 flushed", 32'(instr_valid), 32'h0);
        check("t3 addr20", imem_bus.addr, 32'h0000_0020);

        // Grant withheld: address holds, redirect in REQ, then accept.
        do_reset();
        imem_bus.gnt = 1'b0; dec_ready = 1'b1; lat = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(1); #1;
            check("t4 req held", 32'(imem_bus.req), 32'h1);
            check("t4 addr held", imem_bus.addr, 32'h0);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0203;
        #1;
        check("t4 req masked", 32'(imem_bus.req), 32'h0);
        cyc(1);
        redirect = 1'b0;
        #1;
        check("t4 redirect addr", imem_bus.addr, 32'h0000_0200);
        imem_bus.gnt = 1'b1;
        cyc(1); #1;
        check("t4 addr step", imem_bus.addr, 32'h0000_0204);
        cyc(1); #1;
        check("t4 word pc", instr_pc, 32'h0000_0200);

        // Reset while waiting; the late response must be ignored.
        do_reset();
        imem_bus.gnt = 1'b1; dec_ready = 1'b1; lat = 4;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1; imem_bus.gnt = 1'b0;
        #1;
        check("t5 req", 32'(imem_bus.req), 32'h1);
        check("t5 addr", imem_bus.addr, RESET_PC);
        check("t5 valid", 32'(instr_valid), 32'h0);
        check("t5 instr", instr, 32'h0);
        check("t5 instr_pc", instr_pc, 32'h0);
        cyc(3); #1;
        check("t5 late rvalid ignored", 32'(instr_valid), 32'h0);
        imem_bus.gnt = 1'b1; lat = 1;
        cyc(2); #1;
        check("t5 refetch pc", instr_pc, 32'h0);

`ifdef FETCH_PERF_EN
        // Counter scenario: 2 words fetched, 1 queued + 1 in flight flushed.
        do_reset();
        imem_bus.gnt = 1'b1; dec_ready = 1'b0; lat = 1;
        cyc(4);
        dec_ready = 1'b1;
        cyc(1);
        dec_ready = 1'b0; lat = 3;
        cyc(1);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        cyc(1);
        redirect = 1'b0;
        cyc(2); #1;
        check("t7 perf_fetched", perf_fetched, 32'd2);
        check("t7 perf_flushed", perf_flushed, 32'd2);
`endif

        // Mixed directed traffic: stalls, grant gaps, latencies, back-to-back redirects.
        do_reset();
        rdy_pat = 48'hF3C5_A96E_0FF1;
        gnt_pat = 48'hEFDB_7FF6_BDFF;
        lat_pat = 8'b1001_0011;
        for (int i = 0; i < 48; i++) begin
            dec_ready    = rdy_pat[i];
            imem_bus.gnt = gnt_pat[i];
            lat          = (i % 4 == 0) ? 1 : (lat_pat[i % 8] ? 3 : 2);
            redirect     = (i == 13) || (i == 14) || (i == 30);
            redirect_pc  = (i == 13) ? 32'h0000_1007 :
                           (i == 14) ? 32'h0000_2002 : 32'h0000_3000;
            cyc(1);
        end
        redirect = 1'b0; dec_ready = 1'b1; imem_bus.gnt = 1'b1;
        cyc(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
